// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if -- slot-side bus of the pattern sequencer.
//   swap_req : per-slot level request for a fresh pattern (slot -> sequencer)
//   hit      : per-slot hit level, rising edge = one hit  (slot -> sequencer)
//   swap_ack : one-hot, one-cycle grant pulse            (sequencer -> slot)
//   slot_cmd : 4-bit pattern per slot, slot i on [4i+3:4i] (sequencer -> slot)
interface pattern_sequencer_if #(
  parameter int N_SLOTS = 3
);
  logic [N_SLOTS-1:0]   swap_req;
  logic [N_SLOTS-1:0]   hit;
  logic [N_SLOTS-1:0]   swap_ack;
  logic [4*N_SLOTS-1:0] slot_cmd;

  modport master (output swap_req, output hit, input swap_ack, input slot_cmd);
  modport slave  (input swap_req, input hit, output swap_ack, output slot_cmd);
endinterface

// File: rtl/pattern_sequencer.sv
// pattern_sequencer -- game-level scheduler for the falling-note lanes.
// Owns the LFSR note source, round-robin grants pattern swaps to slots,
// tallies score/combo/misses and runs the IDLE/LOAD/PLAY/OVER game FSM.
//   CLOCK_25  : system clock
//   reset     : asynchronous, active-low reset
//   start     : level, acts in IDLE and OVER
//   bus       : slot bus (swap_req, hit in; swap_ack, slot_cmd out)
//   score     : saturating score
//   combo     : consecutive hits since last miss, saturating at 255
//   misses    : miss count
//   state     : 00 IDLE, 11 LOAD, 01 PLAY, 10 OVER
//   game_over : high while state is OVER
module pattern_sequencer #(
  parameter int         N_SLOTS    = 3,
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         MISS_LIMIT = 5,
  parameter int         SCORE_W    = 14
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               start,
  pattern_sequencer_if.slave bus,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [3:0]         misses,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int RR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_LOAD = 2'b11
  } state_t;

  state_t               state_q, state_n;
  logic [7:0]           lfsr_q, lfsr_n;
  logic [RR_W-1:0]      rr_q, rr_n;
  logic [RR_W-1:0]      ld_q, ld_n;
  logic [4*N_SLOTS-1:0] cmd_q, cmd_n;
  logic [N_SLOTS-1:0]   ack_q, ack_n;
  logic [SCORE_W-1:0]   score_q, score_n;
  logic [7:0]           combo_q, combo_n;
  logic [3:0]           misses_q, misses_n;
  logic [N_SLOTS-1:0]   flag_q, flag_n;
  logic [N_SLOTS-1:0]   hprev_q;

  logic [7:0]           lfsr_step;
  logic [3:0]           pat;
  logic [N_SLOTS-1:0]   elig;
  logic [N_SLOTS-1:0]   gnt;
  logic                 found;
  logic [RR_W-1:0]      gidx;
  logic [N_SLOTS-1:0]   counted;
  logic [3:0]           kcnt;
  logic [4:0]           inc;
  logic [SCORE_W:0]     score_sum;
  logic [8:0]           combo_sum;
  logic                 miss;

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Never issue an empty pattern: fall back to the high nibble, then 4'b1000.
  assign pat = (lfsr_q[3:0] != 4'd0) ? lfsr_q[3:0] :
               (lfsr_q[7:4] != 4'd0) ? lfsr_q[7:4] : 4'b1000;

  // Round-robin search split in two passes (slots at/after rr, then wrap)
  // so every index is a plain loop variable.
  always_comb begin
    elig  = bus.swap_req & ~ack_q;
    gnt   = '0;
    found = 1'b0;
    gidx  = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!found && elig[i] && (i >= 32'(rr_q))) begin
        found = 1'b1;
        gidx  = RR_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        gidx  = RR_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      gnt[i] = found && (gidx == RR_W'(i)) && (state_q == ST_PLAY);
    end
  end

  always_comb begin
    counted = (state_q == ST_PLAY) ? (bus.hit & ~hprev_q & ~flag_q) : '0;
    kcnt    = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      kcnt = kcnt + {3'b000, counted[i]};
    end
    inc       = (combo_q >= 8'd8) ? {kcnt, 1'b0} : {1'b0, kcnt};
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(inc);
    combo_sum = {1'b0, combo_q} + {5'b00000, kcnt};
    // A hit landing on the granted slot in the same cycle still answers the note.
    miss      = |(gnt & ~flag_q & ~counted);
  end

  always_comb begin
    state_n  = state_q;
    lfsr_n   = lfsr_q;
    rr_n     = rr_q;
    ld_n     = ld_q;
    cmd_n    = cmd_q;
    ack_n    = '0;
    score_n  = score_q;
    combo_n  = combo_q;
    misses_n = misses_q;
    flag_n   = flag_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_n  = ST_LOAD;
          ld_n     = '0;
          score_n  = '0;
          combo_n  = '0;
          misses_n = '0;
          flag_n   = '0;
        end
      end
      ST_LOAD: begin
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
          if (ld_q == RR_W'(i)) cmd_n[4*i +: 4] = pat;
        end
        lfsr_n = lfsr_step;
        if (ld_q == RR_W'(N_SLOTS - 1)) begin
          state_n = ST_PLAY;
          rr_n    = '0;
        end else begin
          ld_n = ld_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (found) begin
          ack_n  = gnt;
          lfsr_n = lfsr_step;
          rr_n   = (gidx == RR_W'(N_SLOTS - 1)) ? '0 : gidx + 1'b1;
          for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (gnt[i]) cmd_n[4*i +: 4] = pat;
          end
        end
        score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        flag_n  = (flag_q | counted) & ~gnt;
        if (miss) begin
          combo_n  = '0;
          misses_n = misses_q + 1'b1;
          if (misses_q == 4'(MISS_LIMIT - 1)) state_n = ST_OVER;
        end else begin
          combo_n = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      rr_q     <= '0;
      ld_q     <= '0;
      cmd_q    <= '0;
      ack_q    <= '0;
      score_q  <= '0;
      combo_q  <= '0;
      misses_q <= '0;
      flag_q   <= '0;
      hprev_q  <= '0;
    end else begin
      state_q  <= state_n;
      lfsr_q   <= lfsr_n;
      rr_q     <= rr_n;
      ld_q     <= ld_n;
      cmd_q    <= cmd_n;
      ack_q    <= ack_n;
      score_q  <= score_n;
      combo_q  <= combo_n;
      misses_q <= misses_n;
      flag_q   <= flag_n;
      hprev_q  <= bus.hit;
    end
  end

  assign bus.slot_cmd = cmd_q;
  assign bus.swap_ack = ack_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign misses       = misses_q;
  assign state        = state_q;
  assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer -- table-driven directed bench for pattern_sequencer
// (N_SLOTS=3, SEED=8'hA5, MISS_LIMIT=5, SCORE_W=14).
module tb_pattern_sequencer;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] score;
  logic [7:0]  combo;
  logic [3:0]  misses;
  logic [1:0]  state;
  logic        game_over;

  pattern_sequencer_if #(.N_SLOTS(N)) bus ();

  pattern_sequencer #(
    .N_SLOTS(N),
    .SEED(8'hA5),
    .MISS_LIMIT(5),
    .SCORE_W(14)
  ) dut (
    .CLOCK_25(clk),
    .reset(rst_n),
    .start(start),
    .bus(bus),
    .score(score),
    .combo(combo),
    .misses(misses),
    .state(state),
    .game_over(game_over)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference note source and expected slot contents.
  logic [7:0]  m_lfsr = 8'hA5;
  logic [11:0] exp_cmd = '0;

  typedef struct {
    logic       st;
    logic [2:0] req;
    logic [2:0] hit;
    logic [2:0] upd;   // slots expected to receive a new pattern
    logic [2:0] ack;
    logic [1:0] state;
    int         score;
    int         combo;
    int         misses;
  } vec_t;

  vec_t vt [24];

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic m_issue(input int slot);
    logic [3:0] p;
    if (m_lfsr[3:0] != 4'd0)      p = m_lfsr[3:0];
    else if (m_lfsr[7:4] != 4'd0) p = m_lfsr[7:4];
    else                          p = 4'b1000;
    for (int i = 0; i < N; i++) begin
      if (i == slot) exp_cmd[4*i +: 4] = p;
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int row, input logic [2:0] ack, input logic [1:0] st,
                         input int sc, input int co, input int mi);
    chk("swap_ack", row, 32'(bus.swap_ack), 32'(ack));
    chk("state", row, 32'(state), 32'(st));
    chk("game_over", row, 32'(game_over), 32'(st == 2'b10));
    chk("score", row, 32'(score), 32'(sc));
    chk("combo", row, 32'(combo), 32'(co));
    chk("misses", row, 32'(misses), 32'(mi));
    chk("slot_cmd", row, 32'(bus.slot_cmd), 32'(exp_cmd));
  endtask

  initial begin
    //            st    req     hit     upd     ack     state  sc co mi
    vt[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'b11, 0, 0, 0};
    vt[1]  = '{1'b0, 3'b000, 3'b000, 3'b001, 3'b000, 2'b11, 0, 0, 0};
    vt[2]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b000, 2'b11, 0, 0, 0};
    vt[3]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b000, 2'b01, 0, 0, 0};
    vt[4]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b001, 2'b01, 0, 0, 1};
    vt[5]  = '{1'b0, 3'b110, 3'b000, 3'b010, 3'b010, 2'b01, 0, 0, 2};
    vt[6]  = '{1'b0, 3'b110, 3'b000, 3'b100, 3'b100, 2'b01, 0, 0, 3};
    vt[7]  = '{1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 2'b01, 0, 0, 3};
    vt[8]  = '{1'b0, 3'b000, 3'b010, 3'b000, 3'b000, 2'b01, 1, 1, 3};
    vt[9]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 1, 1, 3};
    vt[10] = '{1'b0, 3'b000, 3'b010, 3'b000, 3'b000, 2'b01, 1, 1, 3};
    vt[11] = '{1'b0, 3'b010, 3'b010, 3'b010, 3'b010, 2'b01, 1, 1, 3};
    vt[12] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 1, 1, 3};
    vt[13] = '{1'b0, 3'b001, 3'b001, 3'b001, 3'b001, 2'b01, 2, 2, 3};
    vt[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 2, 2, 3};
    vt[15] = '{1'b0, 3'b100, 3'b000, 3'b100, 3'b100, 2'b01, 2, 0, 4};
    vt[16] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 2, 0, 4};
    vt[17] = '{1'b0, 3'b001, 3'b010, 3'b001, 3'b001, 2'b10, 3, 0, 5};
    vt[18] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 2'b10, 3, 0, 5};
    vt[19] = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 2'b10, 3, 0, 5};
    vt[20] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'b11, 0, 0, 0};
    vt[21] = '{1'b0, 3'b000, 3'b000, 3'b001, 3'b000, 2'b11, 0, 0, 0};
    vt[22] = '{1'b0, 3'b000, 3'b000, 3'b010, 3'b000, 2'b11, 0, 0, 0};
    vt[23] = '{1'b0, 3'b000, 3'b000, 3'b100, 3'b000, 2'b01, 0, 0, 0};

    bus.swap_req = '0;
    bus.hit      = '0;

    // Reset state
    tick();
    tick();
    chk_all(-1, 3'b000, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_all(-2, 3'b000, 2'b00, 0, 0, 0);

    // Vector table
    for (int r = 0; r < 24; r++) begin
      start        = vt[r].st;
      bus.swap_req = vt[r].req;
      bus.hit      = vt[r].hit;
      tick();
      for (int s = 0; s < N; s++) begin
        if (vt[r].upd[s]) m_issue(s);
      end
      chk_all(r, vt[r].ack, vt[r].state, vt[r].score, vt[r].combo, vt[r].misses);
      if (r == 3) chk("first_load", r, 32'(bus.slot_cmd), 32'h5A5);
    end

    // Nine hit+grant pairs on slot 0: doubling kicks in at combo 8.
    start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      bus.swap_req = 3'b001;
      bus.hit      = 3'b001;
      tick();
      m_issue(0);
      chk_all(100 + n, 3'b001, 2'b01, (n <= 8) ? n : 10, n, 0);
      bus.swap_req = 3'b000;
      bus.hit      = 3'b000;
      tick();
      chk("ack_drop", 100 + n, 32'(bus.swap_ack), 32'h0);
    end
    bus.swap_req = 3'b010;
    tick();
    m_issue(1);
    chk_all(110, 3'b010, 2'b01, 10, 0, 1);
    bus.swap_req = 3'b000;
    tick();

    // Asynchronous reset in the middle of a game
    #5;
    rst_n = 1'b0;
    #1;
    m_lfsr  = 8'hA5;
    exp_cmd = '0;
    chk_all(200, 3'b000, 2'b00, 0, 0, 0);
    tick();
    chk_all(201, 3'b000, 2'b00, 0, 0, 0);
    rst_n = 1'b1;

    // Fresh load after reset restarts the note source from the seed.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < N; s++) begin
      tick();
      m_issue(s);
    end
    chk_all(202, 3'b000, 2'b01, 0, 0, 0);
    chk("reload_cmd", 202, 32'(bus.slot_cmd), 32'h5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
